// File: rtl/dpp_table.sv
// dpp_table: round-robin fork arbiter issuing one-cycle EAT pulses to hungry philosophers
module dpp_table #(
  parameter int N_PHILO = 5,
  parameter int IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*N_PHILO-1:0] philo_state,
  output logic [N_PHILO-1:0]   eat,
  output logic [N_PHILO-1:0]   fork_busy,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 err
);
  localparam logic [1:0] S_HUNGRY = 2'b00;
  localparam logic [1:0] S_THINK  = 2'b01;
  localparam logic [1:0] S_ILLEGAL = 2'b11;
  logic [N_PHILO-1:0] granted, done, cand, pick, granted_nx, busy_nx;
  logic [IDX_W-1:0]   rr_ptr, pick_idx;
  logic               found, illegal;
  always_comb begin
    illegal = 1'b0;
    done = '0;
    cand = '0;
    for (int i = 0; i < N_PHILO; i++) begin
      done[i] = granted[i] && philo_state[2*i +: 2] == S_THINK;
      cand[i] = philo_state[2*i +: 2] == S_HUNGRY && !granted[i] &&
                !fork_busy[i] && !fork_busy[(i+1)%N_PHILO];
      illegal = illegal | (philo_state[2*i +: 2] == S_ILLEGAL);
    end
    found = 1'b0;
    pick = '0;
    pick_idx = '0;
    for (int k = 0; k < N_PHILO; k++) begin
      if (!found && cand[(int'(rr_ptr)+k)%N_PHILO]) begin
        found = 1'b1;
        pick[(int'(rr_ptr)+k)%N_PHILO] = 1'b1;
        pick_idx = IDX_W'((int'(rr_ptr)+k)%N_PHILO);
      end
    end
    // fork ownership derives from the grant set after this edge's releases and grant
    granted_nx = (granted & ~done) | pick;
    busy_nx = '0;
    for (int i = 0; i < N_PHILO; i++)
      if (granted_nx[i]) begin
        busy_nx[i] = 1'b1;
        busy_nx[(i+1)%N_PHILO] = 1'b1;
      end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eat <= '0;
      fork_busy <= '0;
      grant_valid <= 1'b0;
      grant_idx <= '0;
      err <= 1'b0;
      granted <= '0;
      rr_ptr <= '0;
    end else begin
      eat <= pick;
      fork_busy <= busy_nx;
      grant_valid <= found;
      grant_idx <= found ? pick_idx : grant_idx;
      err <= err | illegal;
      granted <= granted_nx;
      rr_ptr <= !found ? rr_ptr : pick_idx == IDX_W'(N_PHILO-1) ? '0 : pick_idx + 1'b1;
    end
  end
endmodule
